// File: rtl/alu_mem_datapath.sv
// Execute/memory stage: conditional ALU with NZCV flags, or load/store to an
// internal word-addressed RAM, producing a registered one-cycle write-back.
module alu_mem_datapath #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] opnd_n,
  input  logic [31:0] opnd_m,
  input  logic        ram_en,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [3:0]  flags
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_ORR  = 4'h4,
    OP_EOR  = 4'h5,
    OP_MOV  = 4'h6,
    OP_MOVR = 4'h7,
    OP_CMP  = 4'h8,
    OP_LDR  = 4'h9,
    OP_STR  = 4'hA
  } opcode_e;

  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  dest;
  logic [15:0] imm16;
  logic [4:0]  shamt;
  logic [2:0]  shtype;

  assign cond   = instr[31:28];
  assign opcode = instr[27:24];
  assign s_bit  = instr[23];
  assign dest   = instr[22:19];
  assign imm16  = instr[18:3];
  assign shamt  = instr[7:3];
  assign shtype = instr[2:0];

  logic [3:0]  flags_q, flags_d;
  logic        wb_en_q;
  logic [3:0]  wb_dest_q;
  logic [31:0] wb_data_q;
  logic [31:0] mem_q [DEPTH];

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = 1'b1;
      4'b0001: cond_pass = flag_z;
      4'b0010: cond_pass = !flag_z && (flag_n == flag_v);
      4'b0011: cond_pass = (flag_n != flag_v);
      4'b0100: cond_pass = !flag_z;
      4'b0101: cond_pass = (flag_n == flag_v);
      4'b0110: cond_pass = flag_z || (flag_n != flag_v);
      4'b0111: cond_pass = flag_n;
      default: cond_pass = 1'b0;
    endcase
  end

  // Rotate via complementary shifts; a left shift by 32 yields 0 when shamt=0.
  logic [31:0] m_sh;
  logic [5:0]  rot_left;
  assign rot_left = 6'd32 - {1'b0, shamt};

  always_comb begin
    m_sh = opnd_m;
    case (shtype)
      3'b001:  m_sh = opnd_m >> shamt;
      3'b010:  m_sh = opnd_m << shamt;
      3'b011:  m_sh = $unsigned($signed(opnd_m) >>> shamt);
      3'b100:  m_sh = (opnd_m >> shamt) | (opnd_m << rot_left);
      default: m_sh = opnd_m;
    endcase
  end

  logic        exec;
  logic [32:0] sum33;
  logic [32:0] diff33;
  logic [31:0] prod;
  logic [31:0] alu_res;
  logic        alu_wr;
  logic        set_flags;
  logic        new_c, new_v;
  logic        ld_go, st_go;
  logic [ADDR_W-1:0] addr;

  assign exec   = instr_valid && cond_pass;
  assign sum33  = {1'b0, opnd_n} + {1'b0, m_sh};
  assign diff33 = {1'b0, opnd_n} - {1'b0, m_sh};
  assign prod   = opnd_n * m_sh;
  assign addr   = opnd_n[ADDR_W-1:0];

  always_comb begin
    alu_res = 32'd0;
    new_c   = flag_c;
    new_v   = flag_v;
    case (opcode)
      OP_ADD: begin
        alu_res = sum33[31:0];
        new_c   = sum33[32];
        new_v   = (opnd_n[31] == m_sh[31]) && (sum33[31] != opnd_n[31]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff33[31:0];
        new_c   = !diff33[32];
        new_v   = (opnd_n[31] != m_sh[31]) && (diff33[31] != opnd_n[31]);
      end
      OP_MUL:  alu_res = prod;
      OP_AND:  alu_res = opnd_n & m_sh;
      OP_ORR:  alu_res = opnd_n | m_sh;
      OP_EOR:  alu_res = opnd_n ^ m_sh;
      OP_MOV:  alu_res = {16'd0, imm16};
      OP_MOVR: alu_res = m_sh;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    alu_wr    = exec && !opcode[3];
    set_flags = exec && ((!opcode[3] && s_bit) || (opcode == OP_CMP));
    ld_go     = exec && (opcode == OP_LDR) && ram_en;
    st_go     = exec && (opcode == OP_STR) && ram_en && !reset;
    flags_d   = flags_q;
    if (set_flags) begin
      flags_d = {alu_res[31], (alu_res == 32'd0), new_c, new_v};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'd0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= 4'd0;
      wb_data_q <= 32'd0;
    end else begin
      flags_q <= flags_d;
      wb_en_q <= alu_wr || ld_go;
      if (alu_wr) begin
        wb_dest_q <= dest;
        wb_data_q <= alu_res;
      end else if (ld_go) begin
        wb_dest_q <= dest;
        wb_data_q <= mem_q[addr];
      end
    end
  end

  // RAM contents survive reset; st_go already excludes a reset cycle.
  always_ff @(posedge clk) begin
    if (st_go) begin
      mem_q[addr] <= opnd_m;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_dest = wb_dest_q;
  assign wb_data = wb_data_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Self-checking bench: directed literal cases followed by randomized traffic,
// all compared against a behavioural model of the execute/memory stage.
module tb_alu_mem_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] opnd_n;
  logic [31:0] opnd_m;
  logic        ram_en;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  alu_mem_datapath #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .opnd_n(opnd_n), .opnd_m(opnd_m), .ram_en(ram_en),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .flags(flags)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  logic [3:0]  e_flags;
  logic        e_wb_en;
  logic [3:0]  e_dest;
  logic [31:0] e_data;
  bit          e_data_known;
  logic [31:0] mmem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] m, input int amt,
                                              input logic [2:0] typ);
    logic [31:0] r;
    r = m;
    case (typ)
      3'b001: r = m >> amt;
      3'b010: r = m << amt;
      3'b011: for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
      3'b100: for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
      default: r = m;
    endcase
    return r;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (c)
      4'd0: return 1;
      4'd1: return z;
      4'd2: return !z && (n == v);
      4'd3: return n != v;
      4'd4: return !z;
      4'd5: return n == v;
      4'd6: return z || (n != v);
      4'd7: return n;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit v, input logic [31:0] ins, input logic [31:0] n,
                            input logic [31:0] m, input bit ren, input bit rst);
    logic [3:0]  op;
    logic [31:0] ms, res;
    logic [63:0] wide;
    longint      sres;
    bit          wr, upd_cv, c, ov;
    int          addr;
    if (rst) begin
      e_flags = 4'd0; e_wb_en = 0; e_dest = 4'd0; e_data = 32'd0; e_data_known = 1;
      return;
    end
    e_wb_en = 0;
    if (!v || !cond_ok(ins[31:28], e_flags)) return;
    op = ins[27:24];
    ms = model_shift(m, int'(ins[7:3]), ins[2:0]);
    addr = int'(n % 65536);
    res = 32'd0; wr = 0; upd_cv = 0; c = 0; ov = 0;
    case (op)
      4'd0: begin
        res = n + ms; wr = 1; upd_cv = 1;
        wide = 64'(n) + 64'(ms);
        c = wide > 64'hFFFF_FFFF;
        sres = longint'($signed(n)) + longint'($signed(ms));
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd1, 4'd8: begin
        res = n - ms; wr = (op == 4'd1); upd_cv = 1;
        c = n >= ms;
        sres = longint'($signed(n)) - longint'($signed(ms));
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      4'd2: begin res = n * ms; wr = 1; end
      4'd3: begin res = n & ms; wr = 1; end
      4'd4: begin res = n | ms; wr = 1; end
      4'd5: begin res = n ^ ms; wr = 1; end
      4'd6: begin res = {16'd0, ins[18:3]}; wr = 1; end
      4'd7: begin res = ms; wr = 1; end
      4'd9: if (ren) begin
        e_wb_en = 1; e_dest = ins[22:19];
        if (mmem.exists(addr)) begin e_data = mmem[addr]; e_data_known = 1; end
        else e_data_known = 0;
      end
      4'd10: if (ren) mmem[addr] = m;
      default: ;
    endcase
    if (wr) begin
      e_wb_en = 1; e_dest = ins[22:19]; e_data = res; e_data_known = 1;
    end
    if ((op < 4'd8 && ins[23]) || op == 4'd8)
      e_flags = {res[31], res == 32'd0, upd_cv ? c : e_flags[1], upd_cv ? ov : e_flags[0]};
  endtask

  task automatic compare_all();
    chk("wb_en", {31'd0, wb_en}, {31'd0, e_wb_en});
    chk("wb_dest", {28'd0, wb_dest}, {28'd0, e_dest});
    if (e_data_known) chk("wb_data", wb_data, e_data);
    chk("flags", {28'd0, flags}, {28'd0, e_flags});
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] n,
                     input logic [31:0] m, input bit ren, input bit rst);
    instr_valid = v; instr = ins; opnd_n = n; opnd_m = m; ram_en = ren; reset = rst;
    model_step(v, ins, n, m, ren, rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] ins, n, m;
    logic [3:0]  op;
    bit          rst, v, ren;
    reset = 1; instr_valid = 0; instr = 0; opnd_n = 0; opnd_m = 0; ram_en = 0;
    e_flags = 0; e_wb_en = 0; e_dest = 0; e_data = 0; e_data_known = 1;
    @(negedge clk);
    cyc(0, 32'h0, 32'h0, 32'h0, 0, 1);
    cyc(1, 32'h0A000000, 32'd5, 32'h1, 1, 1);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);

    // MOV r3, #4
    cyc(1, 32'h06180020, 32'd0, 32'd0, 1, 0);
    chk("mov_wb_en", {31'd0, wb_en}, 32'd1);
    chk("mov_dest", {28'd0, wb_dest}, 32'd3);
    chk("mov_data", wb_data, 32'd4);
    chk("mov_flags", {28'd0, flags}, 32'd0);
    chk("model_mov", e_data, 32'd4);
    // CMP 4,4
    cyc(1, 32'h0801C000, 32'd4, 32'd4, 1, 0);
    chk("cmp_wb_en", {31'd0, wb_en}, 32'd0);
    chk("cmp_flags", {28'd0, flags}, 32'b0110);
    chk("model_cmp_flags", {28'd0, e_flags}, 32'b0110);
    // ADDGT fails with Z=1
    cyc(1, 32'h2009C000, 32'd4, 32'd4, 1, 0);
    chk("addgt_wb_en", {31'd0, wb_en}, 32'd0);
    // MULEQ r2, 4, 4 LSR 1
    cyc(1, 32'h12100009, 32'd4, 32'd4, 1, 0);
    chk("muleq_data", wb_data, 32'd8);
    chk("muleq_dest", {28'd0, wb_dest}, 32'd2);
    // SUBS r7, 4, 8
    cyc(1, 32'h01B80000, 32'd4, 32'd8, 1, 0);
    chk("subs_data", wb_data, 32'hFFFFFFFC);
    chk("subs_flags", {28'd0, flags}, 32'b1000);
    // ADDS overflow
    cyc(1, 32'h00880000, 32'h7FFFFFFF, 32'd1, 1, 0);
    chk("adds_data", wb_data, 32'h80000000);
    chk("adds_flags", {28'd0, flags}, 32'b1001);
    chk("model_adds_flags", {28'd0, e_flags}, 32'b1001);
    // STR then LDR back-to-back
    cyc(1, 32'h0A000000, 32'd0, 32'd26947, 1, 0);
    chk("str_wb_en", {31'd0, wb_en}, 32'd0);
    cyc(1, 32'h09500000, 32'd0, 32'd0, 1, 0);
    chk("ldr_data", wb_data, 32'd26947);
    chk("ldr_dest", {28'd0, wb_dest}, 32'd10);
    chk("ldr_wb_en", {31'd0, wb_en}, 32'd1);
    // STR with ram_en=0 leaves memory alone; LDR with ram_en=0 is silent
    cyc(1, 32'h0A000000, 32'd0, 32'h1234, 0, 0);
    cyc(1, 32'h09500000, 32'hABCD0000, 32'd0, 1, 0);
    chk("str_blocked_data", wb_data, 32'd26947);
    cyc(1, 32'h09500000, 32'd0, 32'd0, 0, 0);
    chk("ldr_blocked_wb_en", {31'd0, wb_en}, 32'd0);
    // Reset during STR to address 5
    cyc(1, 32'h0A000000, 32'd5, 32'hAAAA, 1, 0);
    cyc(1, 32'h0A000000, 32'd5, 32'hBBBB, 1, 1);
    chk("rst_str_flags", {28'd0, flags}, 32'd0);
    chk("rst_str_wb_en", {31'd0, wb_en}, 32'd0);
    cyc(1, 32'h09200000, 32'd5, 32'd0, 1, 0);
    chk("rst_str_mem5", wb_data, 32'hAAAA);
    // Bubble keeps flags
    cyc(1, 32'h0801C000, 32'd4, 32'd4, 1, 0);
    cyc(0, 32'h00880000, 32'h7FFFFFFF, 32'd1, 1, 0);
    chk("bubble_wb_en", {31'd0, wb_en}, 32'd0);
    chk("bubble_flags", {28'd0, flags}, 32'b0110);

    // Preload the small random address window so every load is predictable
    for (int a = 0; a < 16; a++) begin
      n = $urandom; n[15:0] = 16'(a);
      cyc(1, 32'h0A000000, n, $urandom, 1, 0);
    end

    for (int k = 0; k < 3000; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'd0;
      op = ins[27:24];
      n = $urandom;
      if (op == 4'd9 || op == 4'd10) n[15:4] = 12'd0;
      case ($urandom_range(0, 3))
        0: m = 32'd0;
        1: m = n;
        default: m = $urandom;
      endcase
      v   = ($urandom_range(0, 99) < 85);
      ren = ($urandom_range(0, 99) < 80);
      rst = ($urandom_range(0, 99) < 2);
      cyc(v, ins, n, m, ren, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
